seq_scan_ctrl: RTL

Controller that takes parallel data words over a valid/ready handshake and streams each word MSB-first, one bit per cycle, into a pattern-detector core. The core finds overlapping occurrences of the 5-bit sequence 11101. The controller counts matches per word, records the first match position, and returns a result over a second valid/ready handshake. It lets word-oriented producers use the serial sequence detector without driving it bit by bit.

---
 rtl/seq_scan_pkg.sv | 28 ++
 rtl/seq_win_det.sv | 54 +++++
 rtl/seq_scan_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/seq_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_scan_pkg
//  Purpose  : Shared types and default constants for the word-to-serial
//             sequence scanner (seq_scan_ctrl and its detector core).
//  Contents : state_t  - controller state encoding (2 bits)
//             DEF_*    - default word width, pattern, pattern length and
//                        match counter width
//  Revision : 1.0 - initial release
// ============================================================================
package seq_scan_pkg;

  // Controller states, explicitly encoded.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DRAIN  = 2'd2,
    REPORT = 2'd3
  } state_t;

  // Default configuration: 16-bit words, detect 11101 (first bit = MSB).
  localparam int         DEF_DW   = 16;
  localparam int         DEF_PLEN = 5;
  localparam logic [4:0] DEF_PAT  = 5'b11101;
  localparam int         DEF_CW   = 8;

endpackage : seq_scan_pkg
`default_nettype wire

// File: rtl/seq_win_det.sv
`default_nettype none
// ============================================================================
//  Module   : seq_win_det
//  Purpose  : Moore serial pattern detector. Keeps a sliding window of the
//             last PLEN shifted bits plus a saturating fill count, and flags
//             when the window is full and equals PAT. Overlapping matches are
//             found because the window is never cleared on a hit.
//  Ports    : clk      - clock, rising edge
//             rst      - synchronous active-high reset
//             clr      - synchronous history clear (window + fill)
//             shift_en - shift bit_in into the window this cycle
//             bit_in   - serial data bit
//             det      - window full and equal to PAT (registered state only,
//                        so it refers to the bit shifted one edge earlier)
//  Revision : 1.0 - initial release
// ============================================================================
module seq_win_det
  import seq_scan_pkg::*;
#(
  parameter int              PLEN = DEF_PLEN,
  parameter logic [PLEN-1:0] PAT  = DEF_PAT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic shift_en,
  input  logic bit_in,
  output logic det
);

  // Fill counter must be able to hold the value PLEN itself.
  localparam int FW = $clog2(PLEN + 1);

  logic [PLEN-1:0] win;
  logic [FW-1:0]   fill;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      win  <= '0;
      fill <= '0;
    end else if (shift_en) begin
      // Newest bit enters at the LSB so the oldest bit lines up with PAT MSB.
      win <= {win[PLEN-2:0], bit_in};
      if (fill != FW'(PLEN)) begin
        fill <= fill + 1'b1;
      end
    end
  end

  // Gating on fill prevents a false hit while fewer than PLEN bits are known.
  assign det = (fill == FW'(PLEN)) && (win == PAT);

endmodule : seq_win_det
`default_nettype wire

// File: rtl/seq_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seq_scan_ctrl
//  Purpose  : Accepts parallel words over valid/ready, streams each word
//             MSB-first into seq_win_det, counts the matches that end inside
//             the word, records the first match position and returns the
//             result over a second valid/ready handshake.
//  Ports    : clk, rst    - clock (rising edge), synchronous active-high reset
//             in_valid    - input word valid
//             in_ready    - word accepted (high only in IDLE)
//             in_data     - word to scan, bit DW-1 scanned first
//             clear_hist  - sampled with the word: clear detector history
//             out_valid   - result valid (REPORT)
//             out_ready   - consumer accepts result
//             match_cnt   - saturating count of matches ending in this word
//             first_pos   - scan index of the bit completing the first match
//             hit_any     - at least one match in this word
//             busy        - controller not in IDLE
//  Timing   : word accepted at edge 0 -> out_valid high in cycle DW+2;
//             one word every DW+3 cycles with out_ready held high.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter int              DW   = DEF_DW,
  parameter int              PLEN = DEF_PLEN,
  parameter logic [PLEN-1:0] PAT  = DEF_PAT,
  parameter int              CW   = DEF_CW,
  localparam int             PW   = $clog2(DW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          clear_hist,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] match_cnt,
  output logic [PW-1:0] first_pos,
  output logic          hit_any,
  output logic          busy
);

  state_t        state;
  state_t        state_next;

  logic [DW-1:0] shreg;     // remaining bits of the word, next bit at MSB
  logic [PW-1:0] k;         // scan index of the bit presented this cycle

  logic          accept;    // word handshake this cycle
  logic          win_clr;   // clear detector history together with accept
  logic          shift_en;  // present shreg MSB to the core
  logic          det;       // core flag, refers to the bit shifted last edge
  logic          hit_en;    // det is a match credited to the current word
  logic [PW-1:0] hit_pos;   // scan index that det refers to

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and control outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    accept     = 1'b0;
    win_clr    = 1'b0;
    shift_en   = 1'b0;
    hit_en     = 1'b0;
    hit_pos    = '0;

    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          accept     = 1'b1;
          win_clr    = clear_hist;
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        shift_en = 1'b1;
        // det lags the shift by one edge: at k it describes bit k-1. At k=0
        // it describes the last bit of the previous word, already credited.
        hit_en   = det && (k != '0);
        hit_pos  = k - 1'b1;
        if (k == PW'(DW - 1)) begin
          state_next = DRAIN;
        end
      end

      DRAIN: begin
        // Extra cycle so the detect flag for the final bit can be sampled.
        hit_en     = det;
        hit_pos    = PW'(DW - 1);
        state_next = REPORT;
      end

      REPORT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: shift register, scan index and match accounting
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      k         <= '0;
      match_cnt <= '0;
      first_pos <= '0;
      hit_any   <= 1'b0;
    end else if (accept) begin
      shreg     <= in_data;
      k         <= '0;
      match_cnt <= '0;
      first_pos <= '0;
      hit_any   <= 1'b0;
    end else begin
      if (shift_en) begin
        shreg <= {shreg[DW-2:0], 1'b0};
        k     <= k + 1'b1;
      end
      if (hit_en) begin
        if (match_cnt != {CW{1'b1}}) begin
          match_cnt <= match_cnt + 1'b1;
        end
        if (!hit_any) begin
          first_pos <= hit_pos;
        end
        hit_any <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pattern detector core
  // --------------------------------------------------------------------------
  seq_win_det #(
    .PLEN (PLEN),
    .PAT  (PAT)
  ) u_win_det (
    .clk      (clk),
    .rst      (rst),
    .clr      (win_clr),
    .shift_en (shift_en),
    .bit_in   (shreg[DW-1]),
    .det      (det)
  );

endmodule : seq_scan_ctrl
`default_nettype wire
